fp32_serial_sequencer: RTL

Controller that sits between a parallel host and the bit-serial `add_float` core, which has a go/inpab/shift/out_c/over/under/done pin set. The host hands over two IEEE-754 single-precision operands on a valid/ready request channel. The block:

- pulses `go` to the core,
- streams operand A then operand B onto `inpab`,
- deserialises the sum from `out_c`,
- returns sum, overflow/underflow flags and error status on a valid/ready response channel.

One operation is in flight at a time. A watchdog guards against a hung core.

---
 rtl/fp32_seq_pkg.sv | 20 ++
 rtl/fp32_seq_watchdog.sv | 29 ++
 rtl/fp32_serial_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fp32_seq_pkg.sv
// Shared types and constants for the fp32 serial sequencer and its watchdog.
package fp32_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_LOAD      = 3'd2,
        S_COMPUTE   = 3'd3,
        S_UNLOAD    = 3'd4,
        S_DONE_WAIT = 3'd5,
        S_RESP      = 3'd6
    } state_e;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_PROTO   = 1;

    localparam int LOAD_BITS   = 64;
    localparam int UNLOAD_BITS = 32;

endpackage

// File: rtl/fp32_seq_watchdog.sv
// Loadable down-counter; expires when it has counted TIMEOUT_CYCLES enabled cycles since clear.
module fp32_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    // Loaded with TIMEOUT-1 so expiry shows in the last permitted cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= CW'(TIMEOUT_CYCLES - 1);
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expired_o = en_i && (count_q == '0);

endmodule

// File: rtl/fp32_serial_sequencer.sv
// Host-side controller for the bit-serial add_float core: loads {A,B}, unloads the sum,
// reports flags and timeout/protocol errors over a valid/ready response channel.
module fp32_serial_sequencer
    import fp32_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 512,
    parameter int unsigned OP_BITS        = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_BITS-1:0] req_a,
    input  logic [OP_BITS-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [OP_BITS-1:0] res_sum,
    output logic               res_over,
    output logic               res_under,
    output logic [1:0]         res_err,
    output logic               busy,
    output logic               fp_go,
    output logic               fp_inpab,
    input  logic               fp_shift,
    input  logic               fp_out_c,
    input  logic               fp_over,
    input  logic               fp_under,
    input  logic               fp_done
);

    localparam int CNT_W = $clog2(LOAD_BITS + 1);

    state_e                 state_q, state_d;
    logic [LOAD_BITS-1:0]   sh_q, sh_d;
    logic [UNLOAD_BITS-1:0] res_q, res_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   over_q, over_d;
    logic                   under_q, under_d;
    logic [1:0]             err_q, err_d;

    logic wd_clear;
    logic wd_en;
    logic wd_expired;
    logic unload_last;

    assign wd_en       = (state_q != S_IDLE) && (state_q != S_RESP);
    assign unload_last = fp_shift && (cnt_q == CNT_W'(UNLOAD_BITS - 1));

    fp32_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_d  = state_q;
        sh_d     = sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        over_d   = over_q;
        under_d  = under_q;
        err_d    = err_q;
        wd_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    sh_d     = {req_a, req_b};
                    cnt_d    = '0;
                    res_d    = '0;
                    over_d   = 1'b0;
                    under_d  = 1'b0;
                    err_d    = '0;
                    wd_clear = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: state_d = S_LOAD;
            S_LOAD: begin
                if (fp_done) begin
                    err_d[ERR_PROTO] = 1'b1;
                    state_d          = S_RESP;
                end else if (fp_shift) begin
                    sh_d = {sh_q[LOAD_BITS-2:0], 1'b0};
                    if (cnt_q == CNT_W'(LOAD_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (fp_done) begin
                    err_d[ERR_PROTO] = 1'b1;
                    state_d          = S_RESP;
                end else if (fp_shift) begin
                    res_d   = {res_q[UNLOAD_BITS-2:0], fp_out_c};
                    cnt_d   = CNT_W'(1);
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (fp_shift) begin
                    res_d = {res_q[UNLOAD_BITS-2:0], fp_out_c};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A done pulse is legitimate only together with the final strobe.
                if (fp_done && unload_last) begin
                    over_d  = fp_over;
                    under_d = fp_under;
                    state_d = S_RESP;
                end else if (fp_done) begin
                    err_d[ERR_PROTO] = 1'b1;
                    state_d          = S_RESP;
                end else if (unload_last) begin
                    state_d = S_DONE_WAIT;
                end
            end
            S_DONE_WAIT: begin
                if (fp_done) begin
                    over_d  = fp_over;
                    under_d = fp_under;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A hung core overrides whatever the core did in the expiring cycle.
        if (wd_expired) begin
            res_d              = '0;
            over_d             = 1'b0;
            under_d            = 1'b0;
            err_d              = '0;
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = S_RESP;
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are reset too, because res_sum must read 0 straight out of reset.
            state_q <= S_IDLE;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
            under_q <= under_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign fp_go     = (state_q == S_START);
    assign fp_inpab  = (state_q == S_LOAD) && sh_q[LOAD_BITS-1];
    assign res_valid = (state_q == S_RESP);
    assign res_sum   = res_q;
    assign res_over  = over_q;
    assign res_under = under_q;
    assign res_err   = err_q;

endmodule
